fetch_unit: RTL

Instruction fetch stage directly upstream of the instruction memory. It owns the program counter and drives the byte address into the instruction memory. It captures the returned word into an IF/ID holding register with a valid/ready handshake toward decode. It also applies taken-branch redirects and halts fetch when the PC leaves the populated memory range.

---
 rtl/fetch_unit.sv | 90 +++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Purpose: instruction fetch stage; owns the PC, addresses imem, fills a one-entry IF/ID slot.
// Latency: 1 cycle from address presented to id_instr/id_valid; one bubble after a taken branch.
// Backpressure: id_ready low with a full slot freezes id_* and the PC (HOLD) until decode drains it.
module fetch_unit #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter logic [31:0] ADDR_LIMIT = 32'd255
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        id_valid,
  input  logic        id_ready,
  input  logic        br_taken,
  input  logic [31:0] br_pc,
  input  logic [15:0] br_offset,
  output logic        halted,
  output logic [15:0] fetch_count
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] br_target;
  logic [31:0] br_sum;
  logic        accept;
  logic        in_range;

  // Branch target: word offset relative to the instruction after the branch, word aligned.
  always_comb begin
    br_sum    = br_pc + 32'd4 + {{14{br_offset[15]}}, br_offset, 2'b00};
    br_target = {br_sum[31:2], 2'b00};
  end

  assign accept    = !id_valid || id_ready;
  assign in_range  = (pc <= ADDR_LIMIT);
  assign imem_addr = pc;
  assign halted    = (state == ST_HALT);

  // PC, IF/ID slot, capture counter and fetch state; reset beats branch beats everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= PC_RESET;
      id_instr    <= 32'd0;
      id_pc       <= 32'd0;
      id_valid    <= 1'b0;
      fetch_count <= 16'd0;
      state       <= ST_RUN;
    end else if (br_taken) begin
      // Slot holds a wrong-path instruction; drop it regardless of id_ready.
      pc       <= br_target;
      id_valid <= 1'b0;
      state    <= ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (!in_range) begin
            state <= ST_HALT;
            if (id_ready) id_valid <= 1'b0;
          end else if (accept) begin
            id_instr <= imem_data;
            id_pc    <= pc;
            id_valid <= 1'b1;
            pc       <= pc + 32'd4;
            if (fetch_count != 16'hFFFF) fetch_count <= fetch_count + 16'd1;
          end else begin
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          // Exit cycle only drains the slot; the next fetch happens a cycle later.
          if (id_ready) begin
            id_valid <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_HALT: begin
          if (id_ready) id_valid <= 1'b0;
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule
